// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock, with sign fix-up in a final cycle.
module muldiv_unit #(
   parameter int unsigned width = 64
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] hi,
   output logic [width-1:0] lo
);

   localparam int unsigned cnt_w = $clog2(width + 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e             state_q, state_d;
   logic [cnt_w-1:0]   cnt_q, cnt_d;
   logic [2*width-1:0] acc_q, acc_d;
   logic [width-1:0]   opb_q, opb_d;
   logic [width-1:0]   araw_q, araw_d;
   logic [width-1:0]   hi_q, hi_d;
   logic [width-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               sign_a_q, sign_a_d;
   logic               done_q, done_d;

   logic               signed_op;
   logic [width-1:0]   a_mag, b_mag;
   logic [width:0]     mul_sum, div_diff;
   logic [2*width-1:0] prod;
   logic [width-1:0]   quot, rem;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      araw_d   = araw_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      sign_a_d = sign_a_q;
      done_d   = 1'b0;

      signed_op = (op == 3'd0) || (op == 3'd2);
      a_mag     = (signed_op && a[width-1]) ? -a : a;
      b_mag     = (signed_op && b[width-1]) ? -b : b;

      // Multiplier sits in the low half and shifts out as the product shifts in.
      mul_sum  = {1'b0, acc_q[2*width-1:width]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      // Trial subtract of the divisor from the shifted partial remainder.
      div_diff = acc_q[2*width-1:width-1] - {1'b0, opb_q};

      prod = neg_q ? -acc_q : acc_q;
      quot = neg_q ? -acc_q[width-1:0] : acc_q[width-1:0];
      rem  = sign_a_q ? -acc_q[2*width-1:width] : acc_q[2*width-1:width];

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (op <= 3'd3) begin
                  state_d  = StRun;
                  cnt_d    = cnt_w'(width);
                  acc_d    = {{width{1'b0}}, a_mag};
                  opb_d    = b_mag;
                  araw_d   = a;
                  is_div_d = op[1];
                  neg_d    = signed_op & (a[width-1] ^ b[width-1]);
                  sign_a_d = signed_op & a[width-1];
               end else if (op == 3'd4) begin
                  hi_d = a;
               end else if (op == 3'd5) begin
                  lo_d = a;
               end
            end
         end
         StRun: begin
            cnt_d = cnt_q - cnt_w'(1);
            if (!is_div_q) begin
               acc_d = {mul_sum, acc_q[width-1:1]};
            end else if (!div_diff[width]) begin
               acc_d = {div_diff[width-1:0], acc_q[width-2:0], 1'b1};
            end else begin
               acc_d = {acc_q[2*width-2:0], 1'b0};
            end
            if (cnt_q == cnt_w'(1)) state_d = StFix;
         end
         StFix: begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (!is_div_q) begin
               {hi_d, lo_d} = prod;
            end else if (opb_q == '0) begin
               lo_d = '1;
               hi_d = araw_q;
            end else begin
               lo_d = quot;
               hi_d = rem;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         araw_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         sign_a_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         araw_q   <= araw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         sign_a_q <= sign_a_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

   localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  op;
   logic [63:0] a, b;
   logic        busy, done;
   logic [63:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] m_hi, m_lo;   // model HI/LO
   logic [63:0] e_hi, e_lo;   // expected result of the pending op

   muldiv_unit #(.width(64)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural result of an iterative op, straight from the arithmetic rules.
   function automatic void model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                                 output logic [63:0] rh, output logic [63:0] rl);
      logic [127:0] p;
      logic signed [63:0] sx, sy;
      sx = x;
      sy = y;
      rh = '0;
      rl = '0;
      case (o)
         3'd0: begin
            p = {{64{x[63]}}, x} * {{64{y[63]}}, y};
            {rh, rl} = p;
         end
         3'd1: begin
            p = {64'b0, x} * {64'b0, y};
            {rh, rl} = p;
         end
         3'd2: begin
            if (y == 0) begin
               rl = '1; rh = x;
            end else if (x == MinNeg && y == '1) begin
               rl = MinNeg; rh = '0;
            end else begin
               rl = sx / sy; rh = sx % sy;
            end
         end
         default: begin
            if (y == 0) begin
               rl = '1; rh = x;
            end else begin
               rl = x / y; rh = x % y;
            end
         end
      endcase
   endfunction

   // Called at a negedge: presents the op for one edge, returns at the next negedge.
   task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
      model(o, x, y, e_hi, e_lo);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clock);
      start = 1'b0; a = $urandom; b = $urandom;
   endtask

   // Counts remaining busy cycles, then checks the done cycle and result.
   task automatic wait_check(input string tag, input int exp_busy);
      int busy_cnt = 0;
      int done_cnt = 0;
      for (int i = 0; i < 200 && busy; i++) begin
         busy_cnt++;
         if (done) done_cnt++;
         @(negedge clock);
      end
      check({tag, " busy cycles"}, busy_cnt, exp_busy);
      check({tag, " done early"}, done_cnt, 0);
      check({tag, " done"}, done, 1'b1);
      check({tag, " hi"}, hi, e_hi);
      check({tag, " lo"}, lo, e_lo);
      m_hi = e_hi;
      m_lo = e_lo;
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y);
      @(negedge clock);
      issue(o, x, y);
      wait_check(tag, 65);
      @(negedge clock);
      check({tag, " done pulse"}, done, 1'b0);
      check({tag, " idle"}, busy, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clock);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst hi", hi, 64'd0);
      check("rst lo", lo, 64'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("post rst hi", hi, 64'd0);

      run_op("multu 3*4", 3'd1, 64'd3, 64'd4);
      check("multu lo lit", lo, 64'd12);
      run_op("mult -3*5", 3'd0, -64'd3, 64'd5);
      check("mult lo lit", lo, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("multu max*2", 3'd1, '1, 64'd2);
      check("multu hi lit", hi, 64'd1);
      run_op("div -7/2", 3'd2, -64'd7, 64'd2);
      check("div hi lit", hi, '1);
      run_op("divu 7/2", 3'd3, 64'd7, 64'd2);
      run_op("div 7/-2", 3'd2, 64'd7, -64'd2);
      check("div lo lit", lo, -64'd3);
      run_op("div by 0", 3'd2, 64'd10, 64'd0);
      check("div0 hi lit", hi, 64'd10);
      run_op("div -5/0", 3'd2, -64'd5, 64'd0);
      run_op("divu by 0", 3'd3, 64'hDEAD_BEEF, 64'd0);
      run_op("div ovf", 3'd2, MinNeg, '1);
      check("ovf lo lit", lo, MinNeg);

      // MTLO while a divide is running must be ignored
      @(negedge clock);
      issue(3'd2, 64'd1000, 64'd7);
      start = 1'b1; op = 3'd5; a = 64'd5;
      @(negedge clock);
      start = 1'b0;
      check("mtlo busy ignored lo", lo, m_lo);
      wait_check("div after mtlo", 64);

      // MTHI while idle
      @(negedge clock);
      start = 1'b1; op = 3'd4; a = 64'h1234;
      @(negedge clock);
      start = 1'b0;
      m_hi = 64'h1234;
      check("mthi hi", hi, m_hi);
      check("mthi lo", lo, m_lo);
      check("mthi done", done, 1'b0);
      check("mthi busy", busy, 1'b0);
      start = 1'b1; op = 3'd5; a = 64'h55AA;
      @(negedge clock);
      start = 1'b0;
      m_lo = 64'h55AA;
      check("mtlo lo", lo, m_lo);
      check("mtlo hi", hi, m_hi);
      start = 1'b1; op = 3'd6; a = 64'h9999;
      @(negedge clock);
      start = 1'b0;
      check("nop hi", hi, m_hi);
      check("nop lo", lo, m_lo);
      check("nop busy", busy, 1'b0);

      // Back-to-back: second op accepted in the done cycle
      @(negedge clock);
      issue(3'd3, 64'd99, 64'd10);
      wait_check("chain first", 65);
      issue(3'd0, -64'd123456789, 64'd987654321);
      wait_check("chain second", 65);

      // Reset in the middle of a multiply
      @(negedge clock);
      issue(3'd0, 64'd77777, -64'd31);
      repeat (30) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      m_hi = '0; m_lo = '0;
      check("midrst busy", busy, 1'b0);
      check("midrst hi", hi, 64'd0);
      check("midrst lo", lo, 64'd0);
      check("midrst done", done, 1'b0);
      repeat (3) @(negedge clock);
      check("midrst done held", done, 1'b0);
      reset_n = 1'b1;
      run_op("divu 100/7", 3'd3, 64'd100, 64'd7);
      check("divu lo lit", lo, 64'd14);
      check("divu hi lit", hi, 64'd2);

      // Random iterative ops
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  ro;
         logic [63:0] rx, ry;
         ro = 3'($urandom_range(0, 3));
         rx = {$urandom, $urandom};
         ry = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0: ry = 64'($urandom_range(0, 20));
            1: rx = 64'($urandom_range(0, 1000));
            2: begin ry = 64'($signed(32'($urandom_range(0, 40)) - 32'd20)); end
            default: ;
         endcase
         run_op($sformatf("rand%0d op%0d", i, ro), ro, rx, ry);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
